// File: rtl/cas_tape_pkg.sv
// Shared definitions for the cassette tape writer: FSM state encoding,
// default timing constants and small saturating-counter helpers.
package cas_tape_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_SYNCED = 2'd2,
        ST_FLUSH  = 2'd3
    } cas_state_e;

    // Edge interval below which an edge is a mid-cell data pulse (us)
    localparam int unsigned DEF_SPLIT_US   = 32'd500;
    // Edge interval at or above which the block is considered finished (us)
    localparam int unsigned DEF_TIMEOUT_US = 32'd4000;
    // Byte-alignment pattern that follows the leader
    localparam logic [7:0]  DEF_SYNC_BYTE  = 8'h66;

    // 13-bit increment that sticks at all-ones
    function automatic logic [12:0] sat_inc13(input logic [12:0] v);
        if (v == 13'h1FFF) begin
            return v;
        end else begin
            return v + 13'd1;
        end
    endfunction

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/cas_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_data reads as zero while empty. A write
// into a full FIFO is accepted only when a read happens on the same cycle.
module cas_byte_fifo #(
    parameter int unsigned DEPTH = 32'd16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        rd_ok_s;
    logic        wr_ok_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign rd_ok_s = rd_en & ~empty;
    assign wr_ok_s = wr_en & (~full | rd_ok_s);
    assign rd_data = empty ? 8'h00 : mem_r[rd_ptr_r[AW-1:0]];

    // Storage array write port; contents are don't-care until written
    always_ff @(posedge clk_sys) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers with one extra wrap bit for full/empty
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
            end
        end
    end

endmodule

// File: rtl/cas_tape_writer.sv
// Cassette tape capture: measures the interval between rising edges of the
// machine's tape output, splits them into clock and data pulses, hunts for the
// sync byte, then packs every eight committed bits into a byte and buffers it
// for the consumer. A long silence (or enable dropping) ends the block.
// Optional build macro CAS_TAPE_WRITER_STATS_EN adds the err_count output.
module cas_tape_writer
    import cas_tape_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 32'd42,
    parameter int unsigned SPLIT_US   = DEF_SPLIT_US,
    parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
    parameter logic [7:0]  SYNC_BYTE  = DEF_SYNC_BYTE,
    parameter int unsigned FIFO_DEPTH = 32'd16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic        tape_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [15:0] out_addr,
    output logic        active,
    output logic        done,
    output logic        overflow
`ifdef CAS_TAPE_WRITER_STATS_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned     TW           = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam logic [TW-1:0]   TICK_LAST    = TW'(TICK_DIV - 32'd1);
    localparam logic [12:0]     SPLIT_L      = 13'(SPLIT_US);
    localparam logic [12:0]     TIMEOUT_L    = 13'(TIMEOUT_US);
    localparam logic [12:0]     TIMEOUT_M1_L = 13'(TIMEOUT_US - 32'd1);

    cas_state_e     state_r;
    logic [TW-1:0]  tick_cnt_r;
    logic [12:0]    interval_r;
    logic           tape_d_r;
    logic [7:0]     shift_r;
    logic           pending_r;
    logic [2:0]     bit_cnt_r;
    logic           push_r;
    logic [7:0]     push_data_r;
    logic           active_r;
    logic           done_r;
    logic           overflow_r;
    logic [15:0]    out_addr_r;

    logic           tick_s;
    logic           rise_s;
    logic           timeout_s;
    logic           in_block_s;
    logic           start_s;
    logic           data_pulse_s;
    logic           clock_pulse_s;
    logic           dbl_err_s;
    logic [7:0]     commit_val_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           pop_s;

    assign tick_s        = (tick_cnt_r == TICK_LAST);
    assign rise_s        = tape_out & ~tape_d_r;
    assign timeout_s     = (interval_r >= TIMEOUT_L);
    assign in_block_s    = ((state_r == ST_HUNT) || (state_r == ST_SYNCED)) && enable && !timeout_s;
    assign start_s       = (state_r == ST_IDLE) && enable && rise_s;
    assign data_pulse_s  = rise_s && (interval_r < SPLIT_L);
    assign clock_pulse_s = rise_s && (interval_r >= SPLIT_L) && (interval_r < TIMEOUT_L);
    assign dbl_err_s     = in_block_s && data_pulse_s && pending_r;
    assign commit_val_s  = {shift_r[6:0], pending_r};
    assign pop_s         = ~fifo_empty_s & out_ready;

    assign out_valid = ~fifo_empty_s;
    assign out_addr  = out_addr_r;
    assign active    = active_r;
    assign done      = done_r;
    assign overflow  = overflow_r;

    cas_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .wr_en   (push_r),
        .wr_data (push_data_r),
        .rd_en   (pop_s),
        .rd_data (out_data),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Modulo-TICK_DIV prescaler producing the 1 us tick
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1'b1);
        end
    end

    // Delayed tape level for rising-edge detection
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tape_d_r <= 1'b0;
        end else begin
            tape_d_r <= tape_out;
        end
    end

    // Microseconds since the last rising edge, saturating at all-ones
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            interval_r <= 13'd0;
        end else if (rise_s) begin
            interval_r <= 13'd0;
        end else if (tick_s) begin
            interval_r <= sat_inc13(interval_r);
        end
    end

    // Capture FSM: pulse classification, bit packing, sync hunt and block end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= 8'h00;
            pending_r   <= 1'b0;
            bit_cnt_r   <= 3'd0;
            push_r      <= 1'b0;
            push_data_r <= 8'h00;
            active_r    <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            push_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r   <= ST_HUNT;
                        shift_r   <= 8'h00;
                        pending_r <= 1'b0;
                        bit_cnt_r <= 3'd0;
                    end
                end
                ST_HUNT, ST_SYNCED: begin
                    if (!enable || timeout_s) begin
                        // Any partial byte is abandoned here
                        state_r   <= ST_FLUSH;
                        active_r  <= 1'b0;
                        done_r    <= 1'b1;
                        bit_cnt_r <= 3'd0;
                        pending_r <= 1'b0;
                    end else if (data_pulse_s) begin
                        // A repeated data pulse in one cell leaves the bit at 1
                        pending_r <= 1'b1;
                    end else if (clock_pulse_s) begin
                        shift_r   <= commit_val_s;
                        pending_r <= 1'b0;
                        if (state_r == ST_HUNT) begin
                            if (commit_val_s == SYNC_BYTE) begin
                                state_r     <= ST_SYNCED;
                                push_r      <= 1'b1;
                                push_data_r <= SYNC_BYTE;
                                bit_cnt_r   <= 3'd0;
                                active_r    <= 1'b1;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                push_r      <= 1'b1;
                                push_data_r <= commit_val_s;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty_s && !push_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Index of the byte on out_data: restarts with each block, advances per transfer
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            out_addr_r <= 16'd0;
        end else if (start_s) begin
            out_addr_r <= 16'd0;
        end else if (pop_s) begin
            out_addr_r <= out_addr_r + 16'd1;
        end
    end

    // Sticky drop flag; a pop on the same cycle makes room for the push
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (push_r && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end
    end

`ifdef CAS_TAPE_WRITER_STATS_EN
    logic [15:0] err_count_r;

    assign err_count = err_count_r;

    // Error statistics: double data pulses and near-timeout clock intervals
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            err_count_r <= 16'd0;
        end else if (dbl_err_s ||
                     (in_block_s && (state_r == ST_SYNCED) && clock_pulse_s &&
                      (interval_r == TIMEOUT_M1_L))) begin
            err_count_r <= sat_inc16(err_count_r);
        end
    end
`else
    logic unused_stats_s;
    assign unused_stats_s = dbl_err_s ^ (TIMEOUT_M1_L == 13'd0);
`endif

endmodule

// File: tb/tb_cas_tape_writer.sv
// Directed bench for cas_tape_writer. Timing is scaled down (SPLIT_US=2,
// TIMEOUT_US=8, TICK_DIV=42) so each bit cell lasts a few microseconds:
// a data pulse follows the previous edge by 21 cycles (0-1 us), a clock
// pulse follows by 105 cycles (2-3 us), and silence longer than 8 us ends
// the block.
module tb_cas_tape_writer;

    logic        clk_sys   = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic        tape_out  = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_addr;
    logic        active;
    logic        done;
    logic        overflow;
`ifdef CAS_TAPE_WRITER_STATS_EN
    logic [15:0] err_count;
`endif

    int checks   = 0;
    int failures = 0;

    cas_tape_writer #(
        .TICK_DIV   (42),
        .SPLIT_US   (2),
        .TIMEOUT_US (8),
        .SYNC_BYTE  (8'h66),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (enable),
        .tape_out  (tape_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .active    (active),
        .done      (done),
        .overflow  (overflow)
`ifdef CAS_TAPE_WRITER_STATS_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rising edge 'gap' cycles after the previous one; optionally pop on the
    // cycle the FSM's push lands in the FIFO.
    task automatic edge_after(input int gap, input bit pop);
        repeat (gap - 2) @(negedge clk_sys);
        tape_out = 1'b1;
        @(negedge clk_sys);
        if (pop) out_ready = 1'b1;
        @(negedge clk_sys);
        if (pop) out_ready = 1'b0;
        tape_out = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit pop);
        if (b) edge_after(21, 1'b0);
        edge_after(105, pop);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit pop_last);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], pop_last && (i == 0));
        end
    endtask

    task automatic start_block();
        edge_after(105, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int seen;
        seen = 0;
        repeat (700) begin
            @(negedge clk_sys);
            if (done === 1'b1) seen++;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic [15:0] a);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_addr"},  32'(out_addr),  32'(a));
        out_ready = 1'b1;
        @(negedge clk_sys);
        out_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},    32'(out_valid), 32'd0);
        chk({tag, "_data"},     32'(out_data),  32'd0);
        chk({tag, "_addr"},     32'(out_addr),  32'd0);
        chk({tag, "_active"},   32'(active),    32'd0);
        chk({tag, "_done"},     32'(done),      32'd0);
        chk({tag, "_overflow"}, 32'(overflow),  32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_sys);
        check_all_zero("rst");
`ifdef CAS_TAPE_WRITER_STATS_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Sync and data: leader AA x4, 66, 12, 34, silence
        start_block();
        for (int i = 0; i < 4; i++) send_byte(8'hAA, 1'b0);
        chk("s1_hunt_inactive", 32'(active), 32'd0);
        send_byte(8'h66, 1'b0);
        chk("s1_active", 32'(active), 32'd1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        wait_done("s1_done_once");
        chk("s1_active_fell", 32'(active), 32'd0);
        pop_check("s1_b0", 8'h66, 16'd0);
        pop_check("s1_b1", 8'h12, 16'd1);
        pop_check("s1_b2", 8'h34, 16'd2);
        chk("s1_empty", 32'(out_valid), 32'd0);
        chk("s1_addr_hold", 32'(out_addr), 32'd3);
        repeat (4) @(negedge clk_sys);

        // Simultaneous push/pop with a full FIFO
        start_block();
        chk("s3_addr_clear", 32'(out_addr), 32'd0);
        send_byte(8'h66, 1'b0);
        for (int i = 1; i <= 15; i++) send_byte(8'(8'h20 + i), 1'b0);
        chk("s3_head", 32'(out_data), 32'h66);
        send_byte(8'h30, 1'b1);
        chk("s3_no_overflow", 32'(overflow), 32'd0);
        wait_done("s3_done");
        for (int i = 1; i <= 16; i++) pop_check("s3_b", 8'(8'h20 + i), 16'(i));
        chk("s3_empty", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk_sys);

        // Backpressure: 20 bytes captured, only 16 fit
        start_block();
        send_byte(8'h66, 1'b0);
        for (int i = 1; i <= 19; i++) send_byte(8'(8'h40 + i), 1'b0);
        wait_done("s2_done");
        chk("s2_overflow", 32'(overflow), 32'd1);
        pop_check("s2_b0", 8'h66, 16'd0);
        for (int i = 1; i <= 15; i++) pop_check("s2_b", 8'(8'h40 + i), 16'(i));
        chk("s2_lost", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk_sys);

        // Reset in the middle of a block
        start_block();
        send_byte(8'h66, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        chk("s4_active", 32'(active), 32'd1);
        chk("s4_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        check_all_zero("s4_rst");
        reset = 1'b0;
        start_block();
        send_byte(8'h66, 1'b0);
        send_byte(8'h5A, 1'b0);
        wait_done("s4_done");
        pop_check("s4_b0", 8'h66, 16'd0);
        pop_check("s4_b1", 8'h5A, 16'd1);
        chk("s4_empty", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk_sys);

        // Enable dropped while synced, with three bits of a partial byte
        start_block();
        send_byte(8'h66, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("s5_active_before", 32'(active), 32'd1);
        enable = 1'b0;
        @(negedge clk_sys);
        chk("s5_done_pulse", 32'(done), 32'd1);
        chk("s5_active_off", 32'(active), 32'd0);
        @(negedge clk_sys);
        chk("s5_done_single", 32'(done), 32'd0);
        enable = 1'b1;
        pop_check("s5_b0", 8'h66, 16'd0);
        chk("s5_partial_dropped", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk_sys);

`ifdef CAS_TAPE_WRITER_STATS_EN
        // Two data pulses inside one cell: counted once, bit decodes as 1
        start_block();
        send_byte(8'h66, 1'b0);
        edge_after(21, 1'b0);
        edge_after(21, 1'b0);
        edge_after(105, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        chk("s6_err_count", 32'(err_count), 32'd1);
        wait_done("s6_done");
        pop_check("s6_b0", 8'h66, 16'd0);
        pop_check("s6_b1", 8'h80, 16'd1);
        repeat (4) @(negedge clk_sys);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cas_tape_writer.md
CAS_TAPE_WRITER -- requirements
Module: cas_tape_writer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 42, meaning clk_sys cycles per 1 us timing tick.
REQ-002 SHALL have parameter SPLIT_US, default 500, meaning the edge interval below which an edge is a mid-cell data pulse.
REQ-003 SHALL have parameter TIMEOUT_US, default 4000, meaning the edge interval at or above which the block ends.
REQ-004 SHALL have parameter SYNC_BYTE, default 8'h66, meaning the byte-alignment pattern.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning output buffer entries (power of two).
REQ-006 SHALL have ports in this order (clock and reset first):
- clk_sys  in  1  system clock; one clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture armed (OSD record option).
- tape_out  in  1  machine cassette output level, clk_sys domain.
- out_valid  out  1  a byte is available.
- out_ready  in  1  consumer accepts the byte.
- out_data  out  8  captured byte.
- out_addr  out  16  index of the byte currently on out_data.
- active  out  1  synced block in progress.
- done  out  1  single-cycle pulse at block end.
- overflow  out  1  sticky flag: a byte was dropped.

Function
REQ-007 SHALL form a 1 us tick from a modulo-TICK_DIV counter and a 13-bit saturating interval counter that clears on every tape_out rising edge.
REQ-008 SHALL qualify an edge as a tape_out rising edge detected against a one-cycle delayed copy. Falling edges are ignored.
REQ-009 SHALL use states IDLE, HUNT, SYNCED, FLUSH.
- IDLE goes to HUNT on the first edge while enable=1.
- HUNT goes to SYNCED on a sync match.
- HUNT or SYNCED goes to FLUSH on timeout.
- FLUSH goes to IDLE once the FIFO is empty.
REQ-010 SHALL classify an edge by its interval.
- Interval < SPLIT_US: data pulse; sets the pending bit to 1.
- SPLIT_US <= interval < TIMEOUT_US: clock pulse; commits the pending bit (MSB first) into an 8-bit shift register, then clears the pending bit.
REQ-011 SHALL treat a second data pulse within the same cell as an error. The pending bit remains 1.
REQ-012 SHALL, in HUNT, compare the shift register with SYNC_BYTE after every commit. On a match it pushes SYNC_BYTE, zeroes the bit count and asserts active.
REQ-013 SHALL, in SYNCED, push the shift register into the FIFO after every 8th committed bit.
REQ-014 SHALL, on timeout, discard a partial byte, deassert active, and pulse done for one cycle on entry to FLUSH.
REQ-015 SHALL transfer a byte on the cycle when out_valid=1 and out_ready=1.
- out_data and out_valid are driven from the FIFO head with zero-cycle read latency.
- out_addr increments by 1 per transfer and wraps from 16'hFFFF to 0.
REQ-016 SHALL, when a push occurs with the FIFO full, drop the new byte and set overflow. A simultaneous pop on that same cycle frees a slot and the push succeeds.
REQ-017 SHALL ignore edges in IDLE when enable=0. Deasserting enable in HUNT or SYNCED forces FLUSH in the next cycle.
REQ-018 SHALL hold out_addr at its final value through FLUSH and clear it on the IDLE to HUNT transition.

Reset
REQ-019 SHALL, while reset=1 (including mid-block), set state IDLE, empty the FIFO, and clear all counters and the shift register.
REQ-020 SHALL, while reset=1, drive these outputs: out_valid=0, out_data=0, out_addr=0, active=0, done=0, overflow=0.

Configuration
REQ-021 SHALL, with CAS_TAPE_WRITER_STATS_EN defined, add output err_count (16-bit, saturating at 16'hFFFF, reset 0).
- It increments on each REQ-011 error.
- It increments on each SYNCED-state interval that equals TIMEOUT_US-1.
REQ-022 SHALL, without CAS_TAPE_WRITER_STATS_EN, omit the port and its logic entirely, with no other behavioural change.

Structure
REQ-023 SHALL place the state enum and the default constants (SPLIT_US, TIMEOUT_US, SYNC_BYTE) in a shared package cas_tape_pkg.
REQ-024 SHALL implement the buffer as sub-module cas_byte_fifo: synchronous, first-word-fall-through, FIFO_DEPTH x 8, with full/empty outputs.

Verification
REQ-025 SHALL cover these directed scenarios (TICK_DIV=42):
- Sync and data: leader 0xAA x 4, then 0x66, 0x12, 0x34, then 5 ms silence -> bytes 66,12,34 at out_addr 0,1,2; done pulses once; active falls.
- Backpressure: out_ready=0 while 20 bytes are captured -> first 16 bytes retained; overflow=1; bytes 17-20 lost.
- Simultaneous push/pop: FIFO full, pop coincides with push -> no overflow; all bytes retained in order.
- Reset mid-block: reset asserted after 3 bytes -> all outputs 0 next cycle; a subsequent block starts at out_addr 0.
- Enable drop: enable cleared during SYNCED -> FLUSH next cycle; done pulses; partial byte discarded.
- STATS_EN build: two data pulses injected in one cell -> err_count=1; the byte decodes that bit as 1.
